// File: rtl/gip_rfw_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter.
//   RdTypeNone   : destination type meaning "no write"
//   rfw_state_e  : holding-register state (empty / holding one ALU result)
//   rfw_wr_t     : one register-file write (type, register number, data)
package gip_rfw_arbiter_pkg;

  localparam logic [2:0] RdTypeNone = 3'd0;

  typedef enum logic {
    StEmpty = 1'b0,
    StHeld  = 1'b1
  } rfw_state_e;

  typedef struct packed {
    logic [2:0]  rd_type;
    logic [4:0]  rd_r;
    logic [31:0] data;
  } rfw_wr_t;

  function automatic logic rd_is_write(input logic [2:0] rd_type);
    return rd_type != RdTypeNone;
  endfunction

endpackage

// File: rtl/gip_rfw_arbiter.sv
// Register-file write arbiter between the ALU and the memory read-return path.
// Memory cannot stall, so it always wins; a colliding ALU result is parked in a
// one-entry holding register and written on the next memory-free cycle.
// Ports:
//   gip_clock, gip_reset        : clock, synchronous active-high reset
//   alu_rd__type/__r            : ALU destination (type 0 = no write)
//   alu_use_shifter             : pick shifter result over arith/logic result
//   alu_shifter_result          : ALU shifter result
//   alu_arith_logic_result      : ALU arith/logic result
//   mem_rd_valid, mem_rd__*     : memory read-return destination
//   mem_read_data               : memory read data
//   rfw_accepting_alu_rd        : ALU result consumed this cycle (state EMPTY)
//   rfw_wr_valid/__type/__r/_data : registered register-file write
//   alu_stall_count             : saturating count of ALU stall cycles
module gip_rfw_arbiter
  import gip_rfw_arbiter_pkg::*;
(
  input  logic        gip_clock,
  input  logic        gip_reset,
  input  logic [2:0]  alu_rd__type,
  input  logic [4:0]  alu_rd__r,
  input  logic        alu_use_shifter,
  input  logic [31:0] alu_shifter_result,
  input  logic [31:0] alu_arith_logic_result,
  input  logic        mem_rd_valid,
  input  logic [2:0]  mem_rd__type,
  input  logic [4:0]  mem_rd__r,
  input  logic [31:0] mem_read_data,
  output logic        rfw_accepting_alu_rd,
  output logic        rfw_wr_valid,
  output logic [2:0]  rfw_wr__type,
  output logic [4:0]  rfw_wr__r,
  output logic [31:0] rfw_wr_data,
  output logic [15:0] alu_stall_count
);

  rfw_state_e  state_q, state_d;
  rfw_wr_t     hold_q, hold_d;
  rfw_wr_t     wr_q, sel;
  logic        wr_valid_q, sel_valid;
  logic [15:0] stall_q, stall_d;

  logic        alu_req, mem_req;
  rfw_wr_t     alu_wr, mem_wr;

  // A memory return with type none is dropped, not written.
  assign alu_req = rd_is_write(alu_rd__type);
  assign mem_req = mem_rd_valid && rd_is_write(mem_rd__type);

  assign alu_wr = '{rd_type: alu_rd__type, rd_r: alu_rd__r,
                    data: alu_use_shifter ? alu_shifter_result : alu_arith_logic_result};
  assign mem_wr = '{rd_type: mem_rd__type, rd_r: mem_rd__r, data: mem_read_data};

  assign rfw_accepting_alu_rd = (state_q == StEmpty);

  always_comb begin
    sel       = '0;
    sel_valid = 1'b0;
    state_d   = state_q;
    hold_d    = hold_q;
    stall_d   = stall_q;

    if (mem_req) begin
      sel       = mem_wr;
      sel_valid = 1'b1;
      // Collision: park the ALU result so it lands after the memory write.
      if (state_q == StEmpty && alu_req) begin
        hold_d  = alu_wr;
        state_d = StHeld;
      end
    end else if (state_q == StHeld) begin
      sel       = hold_q;
      sel_valid = 1'b1;
      state_d   = StEmpty;
    end else if (alu_req) begin
      sel       = alu_wr;
      sel_valid = 1'b1;
    end

    if (state_q == StHeld && alu_req && stall_q != 16'hFFFF) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge gip_clock) begin
    if (gip_reset) begin
      state_q    <= StEmpty;
      hold_q     <= '0;
      wr_q       <= '0;
      wr_valid_q <= 1'b0;
      stall_q    <= 16'd0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      wr_valid_q <= sel_valid;
      stall_q    <= stall_d;
      // Write fields keep their last value on idle cycles.
      if (sel_valid) begin
        wr_q <= sel;
      end
    end
  end

  assign rfw_wr_valid    = wr_valid_q;
  assign rfw_wr__type    = wr_q.rd_type;
  assign rfw_wr__r       = wr_q.rd_r;
  assign rfw_wr_data     = wr_q.data;
  assign alu_stall_count = stall_q;

endmodule
